// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: op codes, limits and FSM encoding.
// Op codes above ALU_OP_MAX are undefined and never reach the ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  localparam logic [3:0] ALU_OP_MAX = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Only add and subtract give the ALU overflow flag a meaning.
  function automatic logic op_has_ovf(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after last+1,
// wrapping modulo N_REQ. Nothing is granted while en is low.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && en && req[(int'(last) + i) % N_REQ]) begin
        found = 1'b1;
        grant[(int'(last) + i) % N_REQ] = 1'b1;
        grant_idx = IDX_W'((int'(last) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters: round-robin grant, one op in flight,
// fixed IDLE -> EXEC -> RESP sequence, registered result back to the owner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*4-1:0]      req_op,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_overflow,
  output logic                    rsp_illegal,
  output logic                    busy,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [3:0]              alu_op,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_overflow,
  output logic [1:0]              dbg_state
);

  // Handshake: a request is taken in the IDLE cycle where req_valid[i] & req_ready[i];
  // requesters hold valid and operands until then. rsp_valid is a one-cycle pulse.

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   last_q;
  logic [N_REQ-1:0]   grant_q;
  logic [DATA_W-1:0]  a_q, b_q, result_q;
  logic [3:0]         op_q;
  logic               ovf_q, illegal_q;

  logic [N_REQ-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               op_legal;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .last      (last_q),
    .en        (state_q == S_IDLE),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  assign op_legal = (op_q <= ALU_OP_MAX);

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (|req_valid) state_n = S_EXEC;
      S_EXEC:  state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= IDX_W'(N_REQ - 1);
      grant_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= ALU_AND;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_n;
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            a_q     <= req_a[int'(gnt_idx)*DATA_W +: DATA_W];
            b_q     <= req_b[int'(gnt_idx)*DATA_W +: DATA_W];
            op_q    <= req_op[int'(gnt_idx)*4 +: 4];
            grant_q <= gnt;
            last_q  <= gnt_idx;
          end
        end
        S_EXEC: begin
          if (op_legal) begin
            result_q  <= alu_result;
            ovf_q     <= alu_overflow;
            illegal_q <= 1'b0;
          end else begin
            result_q  <= '0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = gnt;
  assign rsp_valid    = (state_q == S_RESP) ? grant_q : '0;
  assign rsp_result   = result_q;
  assign rsp_overflow = ovf_q & op_has_ovf(op_q);
  assign rsp_illegal  = illegal_q;
  assign busy         = (state_q != S_IDLE);
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  // Illegal ops keep the ALU on AND so it never sees an undefined code.
  assign alu_op       = (state_q == S_EXEC && op_legal) ? op_q : ALU_AND;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the ALU side, directed and random
// requests, expected responses from a spec-level model and an expected queue.
module tb_alu_arbiter;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N*4-1:0] req_op;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           rsp_overflow, rsp_illegal, busy;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [3:0]     alu_op;
  logic           alu_overflow;
  logic [1:0]     dbg_state;

  logic [N-1:0]   v;
  logic [W-1:0]   a_t [N];
  logic [W-1:0]   b_t [N];
  logic [3:0]     op_t [N];

  int n_assert = 0;
  int n_fail   = 0;
  int rr_last  = N - 1;
  logic [W+1:0] exp_q[$];

  alu_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  always_comb begin
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_t[i];
      req_b[i*W +: W] = b_t[i];
      req_op[i*4 +: 4] = op_t[i];
    end
  end

  // Stand-in ALU: raw overflow flag is produced for every op, so masking is visible.
  always_comb begin
    logic [W-1:0] s, d;
    s = alu_a + alu_b;
    d = alu_a - alu_b;
    case (alu_op)
      4'd0: alu_result = alu_a & alu_b;
      4'd1: alu_result = alu_a | alu_b;
      4'd2: alu_result = s;
      4'd3: alu_result = d;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = ~(alu_a | alu_b);
      4'd6: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd7: alu_result = {31'd0, alu_a < alu_b};
      4'd8: alu_result = alu_b << alu_a[4:0];
      4'd9: alu_result = alu_b >> alu_a[4:0];
      4'd10: alu_result = W'($signed(alu_b) >>> alu_a[4:0]);
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    if (alu_op == 4'd3) alu_overflow = (alu_a[31] != alu_b[31]) && (d[31] != alu_a[31]);
    else                alu_overflow = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
  end

  // Reference: {illegal, overflow, result} from the op-code table, using 64-bit arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb, sr;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: return {2'b00, a & b};
      4'd1: return {2'b00, a | b};
      4'd2: begin sr = sa + sb; return {1'b0, (sr > 64'sd2147483647) || (sr < -64'sd2147483648), W'(sr)}; end
      4'd3: begin sr = sa - sb; return {1'b0, (sr > 64'sd2147483647) || (sr < -64'sd2147483648), W'(sr)}; end
      4'd4: return {2'b00, a ^ b};
      4'd5: return {2'b00, ~(a | b)};
      4'd6: return {2'b00, (sa < sb) ? 32'd1 : 32'd0};
      4'd7: return {2'b00, ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0};
      4'd8: begin r = {32'd0, b} * (64'd1 << a[4:0]); return {2'b00, r[31:0]}; end
      4'd9: begin r = {32'd0, b} / (64'd1 << a[4:0]); return {2'b00, r[31:0]}; end
      4'd10: begin sr = sb >>> a[4:0]; return {2'b00, W'(sr)}; end
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  function automatic int rr_pick(input logic [N-1:0] vv);
    for (int i = 1; i <= N; i++)
      if (vv[(rr_last + i) % N]) return (rr_last + i) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Driver: called at a falling edge with the state idle; runs one full grant.
  task automatic serve(input bit keep);
    int g, waited;
    logic [W+1:0] e;
    waited = 0;
    #1;
    while (req_ready == '0 && waited < 8) begin
      @(negedge clk); #1; waited++;
    end
    if (req_ready == '0) begin
      check("ready_timeout", 64'(req_ready), 64'(v));
      return;
    end
    g = rr_pick(v);
    check("grant", 64'(req_ready), 64'(1) << g);
    exp_q.push_back(ref_op(op_t[g], a_t[g], b_t[g]));
    rr_last = g;
    @(negedge clk); #1;
    check("exec_busy", 64'(busy), 64'd1);
    check("exec_ready", 64'(req_ready), 64'd0);
    check("exec_alu_op", 64'(alu_op), (op_t[g] <= 4'd10) ? 64'(op_t[g]) : 64'd0);
    check("exec_alu_a", 64'(alu_a), 64'(a_t[g]));
    if (keep) begin
      a_t[g] = $urandom; b_t[g] = $urandom; op_t[g] = 4'($urandom_range(0, 10));
    end else v[g] = 1'b0;
    @(negedge clk); #1;
    check("rsp_valid", 64'(rsp_valid), 64'(1) << g);
    e = exp_q.pop_front();
    check("rsp_result", 64'(rsp_result), 64'(e[W-1:0]));
    check("rsp_overflow", 64'(rsp_overflow), 64'(e[W]));
    check("rsp_illegal", 64'(rsp_illegal), 64'(e[W+1]));
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    op_t[r] = op; a_t[r] = a; b_t[r] = b; v[r] = 1'b1;
  endtask

  initial begin
    v = '0;
    for (int i = 0; i < N; i++) begin a_t[i] = '0; b_t[i] = '0; op_t[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_result", 64'(rsp_result), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);

    // basic add, then overflow and its masking
    set_req(0, 4'd2, 32'd5, 32'd3);              serve(0);
    set_req(1, 4'd2, 32'h7FFF_FFFF, 32'd1);      serve(0);
    set_req(1, 4'd0, 32'h7FFF_FFFF, 32'd1);      serve(0);

    // both requesters continuously valid: strict alternation
    set_req(0, 4'd2, $urandom, $urandom);
    set_req(1, 4'd3, $urandom, $urandom);
    for (int k = 0; k < 6; k++) serve(1);
    v = '0;

    // illegal op, then a subtract that wraps
    set_req(0, 4'd12, $urandom, $urandom);       serve(0);
    set_req(0, 4'd3, 32'd0, 32'd1);              serve(0);

    // reset during EXEC of a req1 SUB: no response, pointer back to N-1
    set_req(1, 4'd3, 32'd9, 32'd4);
    #1;
    check("mid_grant", 64'(req_ready), 64'd2);
    @(negedge clk); #1;
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1; v = '0;
    @(negedge clk); #1;
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_busy_rst", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    check("mid_rsp_after", 64'(rsp_valid), 64'd0);
    rr_last = N - 1;
    set_req(0, 4'd1, $urandom, $urandom);
    set_req(1, 4'd4, $urandom, $urandom);
    serve(0);
    v = '0;
    @(negedge clk);

    // arithmetic shift and unsigned compare
    set_req(0, 4'd10, 32'd4, 32'h8000_0000);     serve(0);
    set_req(0, 4'd7, 32'd1, 32'hFFFF_FFFF);      serve(0);

    // random mix including undefined op codes
    for (int k = 0; k < 24; k++) begin
      v = 2'($urandom_range(1, 3));
      for (int i = 0; i < N; i++) begin
        a_t[i] = $urandom; b_t[i] = $urandom; op_t[i] = 4'($urandom_range(0, 15));
      end
      serve(1'($urandom_range(0, 1)));
    end
    v = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
